// File: rtl/wbuf_drain_sched.sv
// Arbitrates the shared DRAM command port between demand reads and write-buffer drains.
// Drain mode uses high/low watermarks. A burst limit keeps a waiting read from starving. Flush empties the buffer on request.
module wbuf_drain_sched #(
    parameter int DATA_W       = 512,
    parameter int ADDR_W       = 32,
    parameter int WB_DEPTH     = 16,
    parameter int HI_WM        = 12,
    parameter int LO_WM        = 4,
    parameter int MAX_WB_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_push_i,
    input  logic              wb_empty_i,
    output logic              wb_rden_o,
    input  logic [DATA_W-1:0] wb_rdata_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              flush_i,
    output logic              flush_done_o,
    output logic              drain_o,
    output logic              ovf_o
);

    localparam int CNT_W   = $clog2(WB_DEPTH + 1);
    localparam int BURST_W = $clog2(MAX_WB_BURST + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        WB_FETCH,
        WB_LOAD,
        WB_ISSUE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [BURST_W-1:0] burst;
    logic               flush_act;
    logic               wb_avail;
    logic               burst_ok;
    logic               take_wb;

    assign wb_avail = (cnt != '0) && !wb_empty_i;
    assign burst_ok = (burst < BURST_W'(MAX_WB_BURST)) || !rd_req_i;
    // A write wins when draining within the burst budget, or when no read is waiting.
    assign take_wb  = ((drain_o || flush_act) && wb_avail && burst_ok) ||
                      (!rd_req_i && wb_avail);

    // NOTE: the grant is decoded from the registered state and the live ready, so it
    // lands in the same cycle DRAM accepts the read and drops instantly on reset.
    assign rd_gnt_o = (state == RD_ISSUE) && mem_ready_i;

    // NOTE: all state below uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            ovf_o <= 1'b0;
        end else begin
            unique case ({wb_push_i, wb_rden_o})
                2'b10: begin
                    if (cnt == CNT_W'(WB_DEPTH))
                        ovf_o <= 1'b1;
                    else
                        cnt <= cnt + 1'b1;
                end
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_o      <= 1'b0;
            flush_act    <= 1'b0;
            flush_done_o <= 1'b0;
        end else begin
            if (cnt >= CNT_W'(HI_WM))
                drain_o <= 1'b1;
            else if (state == IDLE && cnt <= CNT_W'(LO_WM))
                drain_o <= 1'b0;

            flush_done_o <= 1'b0;
            if (flush_act && state == IDLE && cnt == '0) begin
                flush_act    <= 1'b0;
                flush_done_o <= 1'b1;
            end else if (flush_i) begin
                flush_act <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            burst       <= '0;
            wb_rden_o   <= 1'b0;
            mem_valid_o <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            wb_rden_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take_wb) begin
                        wb_rden_o <= 1'b1;
                        if (burst != BURST_W'(MAX_WB_BURST))
                            burst <= burst + 1'b1;
                        state <= WB_FETCH;
                    end else if (rd_req_i) begin
                        mem_addr_o  <= rd_addr_i;
                        mem_valid_o <= 1'b1;
                        mem_we_o    <= 1'b0;
                        burst       <= '0;
                        state       <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                WB_FETCH: state <= WB_LOAD;
                WB_LOAD: begin
                    mem_wdata_o <= wb_rdata_i;
                    mem_addr_o  <= wb_rdata_i[ADDR_W-1:0];
                    mem_valid_o <= 1'b1;
                    mem_we_o    <= 1'b1;
                    state       <= WB_ISSUE;
                end
                WB_ISSUE: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        mem_we_o    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbuf_drain_sched.sv
// Directed bench for wbuf_drain_sched with a behavioural write buffer and command log.
module tb_wbuf_drain_sched;
    localparam int DATA_W = 512;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wb_push_i = 1'b0;
    logic              wb_empty_i;
    logic              wb_rden_o;
    logic [DATA_W-1:0] wb_rdata_i = '0;
    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i = '0;
    logic              rd_gnt_o;
    logic              mem_valid_o;
    logic              mem_ready_i = 1'b0;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              flush_i = 1'b0;
    logic              flush_done_o;
    logic              drain_o;
    logic              ovf_o;

    logic [DATA_W-1:0] push_data = '0;
    int checks = 0;
    int passes = 0;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    cmd_t log_q[$];
    logic [DATA_W-1:0] buf_q[$];
    int buf_size = 0;
    int rden_cnt = 0;
    int fd_cnt = 0;
    int gnt_seen = 0;
    int rd_target = 0;

    wbuf_drain_sched dut (
        .clk(clk), .rst_n(rst_n),
        .wb_push_i(wb_push_i), .wb_empty_i(wb_empty_i), .wb_rden_o(wb_rden_o),
        .wb_rdata_i(wb_rdata_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o),
        .drain_o(drain_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    // Write buffer model: data appears the cycle after a pop pulse.
    assign wb_empty_i = (buf_size == 0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q.delete();
            buf_size   <= 0;
            wb_rdata_i <= '0;
        end else begin
            if (wb_rden_o && buf_q.size() != 0) wb_rdata_i <= buf_q.pop_front();
            if (wb_push_i) buf_q.push_back(push_data);
            buf_size <= buf_q.size();
        end
    end

    // Read requester: holds the request until each granted read is counted.
    assign rd_req_i = (gnt_seen < rd_target);
    always @(posedge clk) if (rd_gnt_o) gnt_seen <= gnt_seen + 1;

    always @(negedge clk) begin
        cmd_t c;
        if (rst_n && mem_valid_o && mem_ready_i) begin
            c.we = mem_we_o; c.addr = mem_addr_o; c.wdata = mem_wdata_o;
            log_q.push_back(c);
        end
        if (wb_rden_o) rden_cnt++;
        if (flush_done_o) fd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {16{a}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a);
        wb_push_i = 1'b1;
        push_data = pat(a);
        tick();
        wb_push_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wb_push_i = 1'b0;
        flush_i = 1'b0;
        mem_ready_i = 1'b0;
        rd_target = gnt_seen;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({wb_rden_o, rd_gnt_o, mem_valid_o, mem_we_o, flush_done_o, drain_o, ovf_o,
             mem_addr_o, |mem_wdata_o} !== '0)
            $display("FAIL reset_outputs: got flags %b addr %h", {wb_rden_o, rd_gnt_o,
                     mem_valid_o, mem_we_o, flush_done_o, drain_o, ovf_o}, mem_addr_o);
        else passes++;
        checks++;
        if (dut.cnt !== 5'd0) $display("FAIL reset_cnt: got %0d expected 0", dut.cnt);
        else passes++;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_valid_o, wb_rden_o} !== 2'b00)
            $display("FAIL reset_release_idle: got %b expected 00", {mem_valid_o, wb_rden_o});
        else passes++;
    endtask

    task automatic test_idle_write();
        int base, rbase;
        do_reset();
        base = log_q.size();
        rbase = rden_cnt;
        mem_ready_i = 1'b1;
        push(32'h10);
        push(32'h20);
        checks++;
        if (wb_rden_o !== 1'b1) $display("FAIL iw_rden_pulse: got %b expected 1", wb_rden_o);
        else passes++;
        tick();
        checks++;
        if ({wb_rden_o, mem_valid_o} !== 2'b00)
            $display("FAIL iw_load_cycle: got %b expected 00", {wb_rden_o, mem_valid_o});
        else passes++;
        tick();
        checks++;
        if ({mem_valid_o, mem_we_o} !== 2'b11 || mem_addr_o !== 32'h10 || mem_wdata_o !== pat(32'h10))
            $display("FAIL iw_first_issue: got v%b w%b addr %h expected v1 w1 addr 00000010",
                     mem_valid_o, mem_we_o, mem_addr_o);
        else passes++;
        wait_log(base + 2, 40);
        tick();
        tick();
        checks++;
        if (log_q.size() - base !== 2) $display("FAIL iw_cmd_count: got %0d expected 2", log_q.size() - base);
        else passes++;
        if (log_q.size() - base >= 2) begin
            checks++;
            if (log_q[base].addr !== 32'h10 || log_q[base+1].addr !== 32'h20 ||
                log_q[base].we !== 1'b1 || log_q[base+1].we !== 1'b1 ||
                log_q[base+1].wdata !== pat(32'h20))
                $display("FAIL iw_order: got %h,%h expected 00000010,00000020",
                         log_q[base].addr, log_q[base+1].addr);
            else passes++;
        end
        checks++;
        if (rden_cnt - rbase !== 2) $display("FAIL iw_rden_count: got %0d expected 2", rden_cnt - rbase);
        else passes++;
        checks++;
        if (dut.cnt !== 5'd0) $display("FAIL iw_cnt_zero: got %0d expected 0", dut.cnt);
        else passes++;
    endtask

    task automatic test_read_priority();
        int base, gbase;
        do_reset();
        base = log_q.size();
        gbase = gnt_seen;
        mem_ready_i = 1'b1;
        rd_addr_i = 32'h400;
        rd_target = gnt_seen + 1;
        push(32'h100);
        checks++;
        if ({rd_gnt_o, mem_valid_o, mem_we_o} !== 3'b110 || mem_addr_o !== 32'h400)
            $display("FAIL rp_read_issue: got g%b v%b w%b addr %h expected g1 v1 w0 addr 00000400",
                     rd_gnt_o, mem_valid_o, mem_we_o, mem_addr_o);
        else passes++;
        push(32'h200);
        checks++;
        if (rd_gnt_o !== 1'b0) $display("FAIL rp_gnt_one_cycle: got %b expected 0", rd_gnt_o);
        else passes++;
        push(32'h300);
        wait_log(base + 4, 60);
        checks++;
        if (log_q.size() - base !== 4) $display("FAIL rp_cmd_count: got %0d expected 4", log_q.size() - base);
        else passes++;
        if (log_q.size() - base >= 4) begin
            checks++;
            if (log_q[base].we !== 1'b0 || log_q[base].addr !== 32'h400 ||
                log_q[base+1].addr !== 32'h100 || log_q[base+2].addr !== 32'h200 ||
                log_q[base+3].addr !== 32'h300 || log_q[base+3].we !== 1'b1)
                $display("FAIL rp_order: got %h,%h,%h,%h expected 00000400,00000100,00000200,00000300",
                         log_q[base].addr, log_q[base+1].addr, log_q[base+2].addr, log_q[base+3].addr);
            else passes++;
        end
        checks++;
        if (gnt_seen - gbase !== 1) $display("FAIL rp_gnt_count: got %0d expected 1", gnt_seen - gbase);
        else passes++;
    endtask

    task automatic test_drain();
        int base, gbase, bad, wi;
        do_reset();
        base = log_q.size();
        gbase = gnt_seen;
        for (int i = 0; i < 13; i++) push(32'h1000 + 32'(i * 16));
        tick();
        checks++;
        if (drain_o !== 1'b1 || dut.cnt !== 5'd12)
            $display("FAIL dr_enter: got drain %b cnt %0d expected drain 1 cnt 12", drain_o, dut.cnt);
        else passes++;
        rd_addr_i = 32'h800;
        rd_target = gnt_seen + 1;
        mem_ready_i = 1'b1;
        wait_log(base + 14, 300);
        tick();
        tick();
        checks++;
        if (log_q.size() - base !== 14) $display("FAIL dr_cmd_count: got %0d expected 14", log_q.size() - base);
        else passes++;
        if (log_q.size() - base >= 14) begin
            checks++;
            if (log_q[base+8].we !== 1'b0 || log_q[base+8].addr !== 32'h800)
                $display("FAIL dr_read_after_8: got we %b addr %h expected we 0 addr 00000800",
                         log_q[base+8].we, log_q[base+8].addr);
            else passes++;
            bad = 0;
            wi = 0;
            for (int k = 0; k < 14; k++) begin
                if (k != 8) begin
                    if (log_q[base+k].we !== 1'b1 || log_q[base+k].addr !== 32'h1000 + 32'(wi * 16)) bad++;
                    wi++;
                end
            end
            checks++;
            if (bad !== 0) $display("FAIL dr_write_order: got %0d bad writes expected 0", bad);
            else passes++;
        end
        checks++;
        if (drain_o !== 1'b0 || dut.cnt !== 5'd0 || gnt_seen - gbase !== 1)
            $display("FAIL dr_exit: got drain %b cnt %0d gnts %0d expected 0 0 1",
                     drain_o, dut.cnt, gnt_seen - gbase);
        else passes++;
    endtask

    task automatic test_backpressure();
        int base, rbase;
        do_reset();
        base = log_q.size();
        rbase = rden_cnt;
        push(32'hA0);
        push(32'hB0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({mem_valid_o, mem_we_o} !== 2'b11 || mem_addr_o !== 32'hA0 || mem_wdata_o !== pat(32'hA0))
                $display("FAIL bp_stable_%0d: got v%b w%b addr %h expected v1 w1 addr 000000a0",
                         i, mem_valid_o, mem_we_o, mem_addr_o);
            else passes++;
            tick();
        end
        checks++;
        if (rden_cnt - rbase !== 1) $display("FAIL bp_no_extra_rden: got %0d expected 1", rden_cnt - rbase);
        else passes++;
        mem_ready_i = 1'b1;
        wait_log(base + 2, 40);
        tick();
        checks++;
        if (log_q.size() - base !== 2 || rden_cnt - rbase !== 2)
            $display("FAIL bp_complete: got cmds %0d rden %0d expected 2 2", log_q.size() - base, rden_cnt - rbase);
        else passes++;
    endtask

    task automatic test_flush_ovf();
        int base, fbase, k;
        do_reset();
        base = log_q.size();
        push(32'h300);
        push(32'h310);
        push(32'h320);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        fbase = fd_cnt;
        tick();
        tick();
        tick();
        checks++;
        if (fd_cnt - fbase !== 0) $display("FAIL fl_early_done: got %0d expected 0", fd_cnt - fbase);
        else passes++;
        mem_ready_i = 1'b1;
        k = 0;
        while (flush_done_o !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        checks++;
        if (flush_done_o !== 1'b1 || log_q.size() - base !== 3)
            $display("FAIL fl_done_after_writes: got done %b writes %0d expected 1 3",
                     flush_done_o, log_q.size() - base);
        else passes++;
        tick();
        tick();
        tick();
        checks++;
        if (fd_cnt - fbase !== 1) $display("FAIL fl_single_pulse: got %0d expected 1", fd_cnt - fbase);
        else passes++;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++;
        if (flush_done_o !== 1'b0) $display("FAIL fl_empty_c1: got %b expected 0", flush_done_o);
        else passes++;
        tick();
        checks++;
        if (flush_done_o !== 1'b1) $display("FAIL fl_empty_c2: got %b expected 1", flush_done_o);
        else passes++;
        tick();
        checks++;
        if (flush_done_o !== 1'b0) $display("FAIL fl_empty_c3: got %b expected 0", flush_done_o);
        else passes++;

        // Overflow: a stalled read keeps the port busy so nothing is popped.
        do_reset();
        rd_addr_i = 32'h900;
        rd_target = gnt_seen + 1;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                checks++;
                if (ovf_o !== 1'b0 || dut.cnt !== 5'd16)
                    $display("FAIL ov_full_no_ovf: got ovf %b cnt %0d expected 0 16", ovf_o, dut.cnt);
                else passes++;
            end
            push(32'h2000 + 32'(i * 16));
        end
        checks++;
        if (ovf_o !== 1'b1 || dut.cnt !== 5'd16)
            $display("FAIL ov_set: got ovf %b cnt %0d expected 1 16", ovf_o, dut.cnt);
        else passes++;
        tick();
        tick();
        checks++;
        if (ovf_o !== 1'b1 || {mem_valid_o, mem_we_o} !== 2'b10)
            $display("FAIL ov_sticky: got ovf %b v%b w%b expected 1 v1 w0", ovf_o, mem_valid_o, mem_we_o);
        else passes++;
    endtask

    task automatic test_reset_midop();
        int gbase;
        do_reset();
        gbase = gnt_seen;
        rd_addr_i = 32'h444;
        rd_target = gnt_seen + 1;
        tick();
        tick();
        checks++;
        if ({mem_valid_o, mem_we_o} !== 2'b10 || mem_addr_o !== 32'h444)
            $display("FAIL rm_read_stalled: got v%b w%b addr %h expected v1 w0 addr 00000444",
                     mem_valid_o, mem_we_o, mem_addr_o);
        else passes++;
        mem_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_rden_o, rd_gnt_o, mem_valid_o, mem_we_o, flush_done_o, drain_o, ovf_o,
             mem_addr_o, |mem_wdata_o} !== '0)
            $display("FAIL rm_outputs_zero: got flags %b addr %h", {wb_rden_o, rd_gnt_o,
                     mem_valid_o, mem_we_o, flush_done_o, drain_o, ovf_o}, mem_addr_o);
        else passes++;
        rd_target = gnt_seen;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (dut.cnt !== 5'd0 || mem_valid_o !== 1'b0 || gnt_seen - gbase !== 0)
            $display("FAIL rm_idle_after: got cnt %0d valid %b gnts %0d expected 0 0 0",
                     dut.cnt, mem_valid_o, gnt_seen - gbase);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_idle_write();
        test_read_priority();
        test_drain();
        test_backpressure();
        test_flush_ovf();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
